// File: rtl/parity_serial_tx_if.sv
// Parallel producer handshake into the parity serial transmitter.
//   data_in   : word to send, sampled only on an accepted handshake
//   valid_in  : producer has a word on data_in
//   ready_out : transmitter can accept a word this cycle
// master = producer side, slave = transmitter side.
interface parity_serial_tx_if #(
  parameter int unsigned DATA_W = 3
);

  logic [DATA_W-1:0] data_in;
  logic              valid_in;
  logic              ready_out;

  modport master (
    output data_in,
    output valid_in,
    input  ready_out
  );

  modport slave (
    input  data_in,
    input  valid_in,
    output ready_out
  );

endinterface

// File: rtl/parity_serial_tx.sv
// Serial transmitter: one DATA_W-bit word per asynchronous frame.
// Frame: start (0), data LSB first, even-parity bit, stop (1); each bit held
// CLKS_PER_BIT cycles. The line idles high.
// Ports:
//   clk        : system clock, rising edge
//   rst        : synchronous reset, active-high, overrides everything
//   s_if       : slave side of the valid/ready word handshake
//   tx_out     : serial line
//   busy       : frame in progress (START..STOP)
//   frame_done : one-cycle pulse in the first IDLE cycle after STOP
module parity_serial_tx #(
  parameter int unsigned DATA_W       = 3,
  parameter int unsigned CLKS_PER_BIT = 4
) (
  input  logic              clk,
  input  logic              rst,
  parity_serial_tx_if.slave s_if,
  output logic              tx_out,
  output logic              busy,
  output logic              frame_done
);

  localparam int unsigned BAUD_W = (CLKS_PER_BIT > 1) ? $clog2(CLKS_PER_BIT) : 1;
  localparam int unsigned BIT_W  = (DATA_W > 1) ? $clog2(DATA_W) : 1;

  localparam logic [BAUD_W-1:0] BAUD_LAST = BAUD_W'(CLKS_PER_BIT - 1);
  localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(DATA_W - 1);

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_START  = 3'd1,
    S_DATA   = 3'd2,
    S_PARITY = 3'd3,
    S_STOP   = 3'd4
  } state_t;

  state_t              r_state;
  state_t              w_state_nxt;
  logic [BAUD_W-1:0]   r_baud;
  logic [BAUD_W-1:0]   w_baud_nxt;
  logic [BIT_W-1:0]    r_bit;
  logic [BIT_W-1:0]    w_bit_nxt;
  logic [DATA_W-1:0]   r_shift;
  logic [DATA_W-1:0]   w_shift_nxt;
  logic                r_parity;
  logic                w_parity_nxt;

  logic                r_tx;
  logic                r_ready;
  logic                r_busy;
  logic                r_done;
  logic                w_tx_nxt;
  logic                w_ready_nxt;
  logic                w_busy_nxt;
  logic                w_done_nxt;

  logic                w_accept;
  logic                w_bit_end;

  // Handshake only matters in IDLE; valid_in is ignored mid-frame.
  assign w_accept  = s_if.valid_in && (r_state == S_IDLE);
  assign w_bit_end = (r_baud == BAUD_LAST);

  // State register.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_state_nxt;
    end
  end

  // Next state plus the counters / shift register that move with it.
  always_comb begin
    w_state_nxt  = r_state;
    w_baud_nxt   = r_baud;
    w_bit_nxt    = r_bit;
    w_shift_nxt  = r_shift;
    w_parity_nxt = r_parity;

    // Baud counter paces every non-idle bit and wraps at the bit boundary.
    if (r_state != S_IDLE) begin
      w_baud_nxt = w_bit_end ? '0 : r_baud + BAUD_W'(1);
    end

    unique case (r_state)
      S_IDLE: begin
        w_baud_nxt = '0;
        if (w_accept) begin
          w_shift_nxt  = s_if.data_in;
          w_parity_nxt = ^s_if.data_in;
          w_bit_nxt    = '0;
          w_state_nxt  = S_START;
        end
      end
      S_START: begin
        if (w_bit_end) begin
          w_state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        if (w_bit_end) begin
          w_shift_nxt = r_shift >> 1;
          if (r_bit == BIT_LAST) begin
            w_bit_nxt   = '0;
            w_state_nxt = S_PARITY;
          end else begin
            w_bit_nxt = r_bit + BIT_W'(1);
          end
        end
      end
      S_PARITY: begin
        if (w_bit_end) begin
          w_state_nxt = S_STOP;
        end
      end
      S_STOP: begin
        if (w_bit_end) begin
          w_state_nxt = S_IDLE;
        end
      end
      default: begin
        w_state_nxt = S_IDLE;
      end
    endcase
  end

  // Output decode from the upcoming state so every output is a flop
  // that lines up with the state it describes (start bit the cycle after accept).
  always_comb begin
    w_tx_nxt    = 1'b1;
    w_ready_nxt = 1'b0;
    w_busy_nxt  = 1'b1;
    w_done_nxt  = 1'b0;

    unique case (w_state_nxt)
      S_IDLE: begin
        w_ready_nxt = 1'b1;
        w_busy_nxt  = 1'b0;
        w_done_nxt  = (r_state == S_STOP);
      end
      S_START: begin
        w_tx_nxt = 1'b0;
      end
      S_DATA: begin
        w_tx_nxt = w_shift_nxt[0];
      end
      S_PARITY: begin
        w_tx_nxt = w_parity_nxt;
      end
      default: begin
        w_tx_nxt = 1'b1;
      end
    endcase
  end

  // Datapath registers; reset discards any latched word.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_baud   <= '0;
      r_bit    <= '0;
      r_shift  <= '0;
      r_parity <= 1'b0;
    end else begin
      r_baud   <= w_baud_nxt;
      r_bit    <= w_bit_nxt;
      r_shift  <= w_shift_nxt;
      r_parity <= w_parity_nxt;
    end
  end

  // Output registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_tx    <= 1'b1;
      r_ready <= 1'b1;
      r_busy  <= 1'b0;
      r_done  <= 1'b0;
    end else begin
      r_tx    <= w_tx_nxt;
      r_ready <= w_ready_nxt;
      r_busy  <= w_busy_nxt;
      r_done  <= w_done_nxt;
    end
  end

  assign tx_out         = r_tx;
  assign s_if.ready_out = r_ready;
  assign busy           = r_busy;
  assign frame_done     = r_done;

endmodule

// File: doc/parity_serial_tx.md
Name: parity_serial_tx

Overview:
- Serial transmitter that sends a DATA_W-bit word as one asynchronous frame on a single line.
- Frame order: start bit, data bits LSB first, one even-parity bit, stop bit.
- The data bits plus the parity bit always carry an even number of ones, so the receiving end's 4-input even-parity check (DATA_W=3) accepts every valid frame.
- Sits between a parallel producer (valid/ready handshake) and the serial link.

Parameters:
DATA_W, 3, data bits per frame (>=1)
CLKS_PER_BIT, 4, clock cycles each serial bit is held on tx_out (>=1)

Ports:
clk  input  1  system clock, all logic on rising edge
rst  input  1  synchronous reset, active-high
data_in  input  DATA_W  word to send; sampled only on an accepted handshake
valid_in  input  1  producer has a word on data_in
ready_out  output  1  transmitter can accept a word this cycle
tx_out  output  1  serial line, idles high
busy  output  1  high while a frame is in progress (START..STOP)
frame_done  output  1  one-cycle pulse when a frame's stop bit completes

Behaviour:
- Interface: one clock (clk); reset rst is synchronous and active-high.
- Reset values: tx_out=1, ready_out=1, busy=0, frame_done=0, state=IDLE, bit counter=0, baud counter=0, shift register=0.
- rst has priority over every other input.
- States: IDLE, START, DATA, PARITY, STOP.
- Handshake:
  - Accept when valid_in && ready_out at a rising edge.
  - ready_out = (state==IDLE), registered, not a combinational function of valid_in.
  - On accept, latch data_in into the shift register and compute parity = XOR of data_in (even parity), then enter START.
  - data_in and valid_in are ignored while not in IDLE.
- Latency: tx_out drives the start bit (0) the cycle after the accept edge.
- Bit timing:
  - Baud counter runs 0..CLKS_PER_BIT-1.
  - Each state holds its bit for exactly CLKS_PER_BIT cycles.
  - The state advances when the counter reaches CLKS_PER_BIT-1; the counter wraps to 0.
  - CLKS_PER_BIT=1 gives one cycle per bit.
- START: tx_out=0 -> DATA.
- DATA:
  - tx_out = shift register bit 0.
  - At the end of each bit, shift right and increment the bit counter.
  - After DATA_W bits -> PARITY; the bit counter resets to 0.
- PARITY: tx_out = latched parity bit -> STOP.
- STOP: tx_out=1; at end of the bit -> IDLE.
- frame_done pulses high for exactly the first IDLE cycle after STOP.
- Frame length: (DATA_W+3)*CLKS_PER_BIT cycles from the first start-bit cycle to the last stop-bit cycle inclusive.
- Back-to-back:
  - In the IDLE cycle where frame_done=1, ready_out=1.
  - If valid_in=1 in that cycle, the word is accepted and the next start bit begins on the following cycle.
  - Minimum inter-frame gap: 1 idle (high) cycle.
- busy = state!=IDLE, registered, consistent with ready_out = !busy.
- Reset mid-frame: at the rst edge tx_out returns to 1, the frame is abandoned, frame_done stays 0, and the latched word is discarded.
- Counter widths: $clog2 sized, minimum 1 bit; no overflow possible under these rules.

Test Plan:
1. rst=1 for 3 cycles, then release -> tx_out=1, ready_out=1, busy=0, frame_done=0 throughout; no frame starts while valid_in=0.
2. DATA_W=3, CLKS_PER_BIT=4; accept data_in=3'b101 -> tx_out sequence 0,1,0,1,0(parity),1, each bit held 4 cycles (24 cycles total). frame_done pulses once at cycle 25. Data+parity ones-count is even.
3. Accept data_in=3'b100 -> bits 0,0,0,1,1(parity),1. Accept 3'b000 -> 0,0,0,0,0,1. Receiver-side even-parity check passes for both.
4. Hold valid_in=1 with 3'b111 then 3'b011 -> second start bit begins the cycle after the frame_done pulse (one high gap cycle). Parity bits are 1 then 0. Changes on data_in during the first frame do not alter the first frame.
5. Assert rst for 1 cycle during the DATA state of a 3'b110 frame -> next cycle tx_out=1, ready_out=1, busy=0, no frame_done. A new word accepted afterwards transmits cleanly from the start bit.
6. CLKS_PER_BIT=1, data_in=3'b001 -> frame 0,1,0,0,1,1 over 6 consecutive cycles; frame_done on cycle 7.
